// File: rtl/mult_unit_seq.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product with a start/busy/done handshake.
// Optional two's-complement support is enabled with the SIGNED_MULT_EN macro.
module mult_unit_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned ACC_W  = 2 * WIDTH + 1;
    localparam int unsigned PROD_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               sign_q, sign_d;

    logic [WIDTH:0]     sum_c;
    logic [ACC_W-1:0]   acc_step_c;
    logic [PROD_W-1:0]  prod_c;
    logic               last_c;
    logic [WIDTH-1:0]   a_op_c, b_op_c;
    logic               sign_op_c;

    // Operand conditioning at accept: magnitudes plus result sign when signed mode is built in
`ifdef SIGNED_MULT_EN
    always_comb begin
        a_op_c    = (signed_op && a[WIDTH-1]) ? WIDTH'(WIDTH'(0) - a) : a;
        b_op_c    = (signed_op && b[WIDTH-1]) ? WIDTH'(WIDTH'(0) - b) : b;
        sign_op_c = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
    end
`else
    logic unused_signed_op;
    assign unused_signed_op = signed_op;

    always_comb begin
        a_op_c    = a;
        b_op_c    = b;
        sign_op_c = 1'b0;
    end
`endif

    // One shift-add step; carry is kept in the extra top accumulator bit
    always_comb begin
        sum_c      = acc_q[ACC_W-1:WIDTH] + (mplier_q[0] ? {1'b0, mcand_q} : (WIDTH+1)'(0));
        acc_step_c = {sum_c, acc_q[WIDTH-1:0]} >> 1;
        prod_c     = acc_step_c[PROD_W-1:0];
`ifdef SIGNED_MULT_EN
        if (sign_q) begin
            prod_c = PROD_W'(PROD_W'(0) - acc_step_c[PROD_W-1:0]);
        end
`endif
        last_c     = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_BUSY;
            S_BUSY:  if (last_c) state_d = S_DONE;
            S_DONE:  state_d = start ? S_BUSY : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; start is only honoured outside BUSY
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        sign_d   = sign_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d   = 1'b1;
                    mcand_d  = a_op_c;
                    mplier_d = b_op_c;
                    acc_d    = '0;
                    cnt_d    = '0;
                    sign_d   = sign_op_c;
                end
            end
            S_BUSY: begin
                acc_d    = acc_step_c;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_c) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    hi_d   = prod_c[PROD_W-1:WIDTH];
                    lo_d   = prod_c[WIDTH-1:0];
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            sign_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            sign_q   <= sign_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_unit_seq.sv
// Self-checking bench for mult_unit_seq: directed scenarios plus random operands against an arithmetic reference.
// Build with +define+SIGNED_MULT_EN to check the signed variant.
module tb_mult_unit_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    mult_unit_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic [63:0]        ux;
        logic [63:0]        uy;
        ux = {32'd0, x};
        uy = {32'd0, y};
`ifdef SIGNED_MULT_EN
        if (s) begin
            sx = $signed(x);
            sy = $signed(y);
            return sx * sy;
        end
`else
        sx = '0;
        sy = '0;
        if (s) ux = ux + 64'(sx) + 64'(sy);
`endif
        return ux * uy;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply and wait (bounded) for done; operands are scrambled right after accept
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic sop,
                          output int lat, output int busy_bad, output int hold_bad);
        logic [31:0] ph;
        logic [31:0] pl;
        ph = hi;
        pl = lo;
        a = ia; b = ib; signed_op = sop; start = 1'b1;
        tick();
        start = 1'b0; a = $urandom; b = $urandom; signed_op = 1'($urandom);
        lat = 0; busy_bad = 0; hold_bad = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1) busy_bad++;
            if (hi !== ph || lo !== pl) hold_bad++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; signed_op = 1'b0; a = '0; b = '0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if ({hi, lo} !== 64'd0) begin failures++; $display("FAIL reset_hilo got=%h_%h exp=0", hi, lo); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat, bb, hb;
        run_op(32'd3, 32'd5, 1'b0, lat, bb, hb);
        checks++; if (lat !== 32) begin failures++; $display("FAIL basic_latency got=%0d exp=32", lat); end
        checks++; if (bb !== 0) begin failures++; $display("FAIL basic_busy_window got=%0d low cycles exp=0", bb); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got=%0b exp=0", busy); end
        checks++; if (hi !== 32'h0 || lo !== 32'hF) begin failures++; $display("FAIL basic_result got=%h_%h exp=00000000_0000000f", hi, lo); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%0b exp=0", done); end
        tick(); tick();
        checks++; if (hi !== 32'h0 || lo !== 32'hF) begin failures++; $display("FAIL basic_hold got=%h_%h exp=00000000_0000000f", hi, lo); end
    endtask

    task automatic test_all_ones();
        int lat, bb, hb;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bb, hb);
        checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h1) begin failures++; $display("FAIL all_ones got=%h_%h exp=fffffffe_00000001", hi, lo); end
        tick();
    endtask

    task automatic test_signed();
        int lat, bb, hb;
        logic [63:0] exp_v;
`ifdef SIGNED_MULT_EN
        exp_v = 64'hFFFF_FFFF_FFFF_FFF1;
`else
        exp_v = 64'h0000_0004_FFFF_FFF1;
`endif
        run_op(32'hFFFF_FFFD, 32'd5, 1'b1, lat, bb, hb);
        checks++; if ({hi, lo} !== exp_v) begin failures++; $display("FAIL signed_neg3x5 got=%h_%h exp=%h", hi, lo, exp_v); end
        checks++; if (lat !== 32) begin failures++; $display("FAIL signed_latency got=%0d exp=32", lat); end
        tick();
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, lat, bb, hb);
        checks++; if (hi !== 32'h4000_0000 || lo !== 32'h0) begin failures++; $display("FAIL signed_minmin got=%h_%h exp=40000000_00000000", hi, lo); end
        tick();
    endtask

    task automatic test_start_ignored();
        int lat;
        a = 32'd3; b = 32'd5; signed_op = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (lat == 9) begin start = 1'b1; a = 32'd7; b = 32'd7; end
            else start = 1'b0;
            tick();
            lat++;
        end
        checks++; if (lat !== 32) begin failures++; $display("FAIL ignore_latency got=%0d exp=32", lat); end
        checks++; if (hi !== 32'h0 || lo !== 32'hF) begin failures++; $display("FAIL ignore_result got=%h_%h exp=00000000_0000000f", hi, lo); end
        a = 32'd7; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_accept got busy=%0b done=%0b exp busy=1 done=0", busy, done); end
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin tick(); lat++; end
        checks++; if (lat !== 32) begin failures++; $display("FAIL b2b_latency got=%0d exp=32", lat); end
        checks++; if (hi !== 32'h0 || lo !== 32'h31) begin failures++; $display("FAIL b2b_result got=%h_%h exp=00000000_00000031", hi, lo); end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, bb, hb;
        a = 32'd3; b = 32'd5; signed_op = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midreset_ctrl got busy=%0b done=%0b exp 0 0", busy, done); end
        checks++; if ({hi, lo} !== 64'd0) begin failures++; $display("FAIL midreset_hilo got=%h_%h exp=0", hi, lo); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_idle got busy=%0b exp=0", busy); end
        run_op(32'd2, 32'd2, 1'b0, lat, bb, hb);
        checks++; if (lat !== 32) begin failures++; $display("FAIL midreset_latency got=%0d exp=32", lat); end
        checks++; if (hi !== 32'h0 || lo !== 32'h4) begin failures++; $display("FAIL midreset_result got=%h_%h exp=00000000_00000004", hi, lo); end
        tick();
    endtask

    task automatic test_zero_hold();
        int lat, bb, hb;
        logic [31:0] x, y;
        logic [63:0] exp_v;
        x = $urandom | 32'h8000_0001;
        y = $urandom | 32'h8000_0001;
        exp_v = ref_mul(x, y, 1'b0);
        run_op(x, y, 1'b0, lat, bb, hb);
        checks++; if ({hi, lo} !== exp_v) begin failures++; $display("FAIL zero_prev got=%h_%h exp=%h", hi, lo, exp_v); end
        tick();
        run_op(32'h0, 32'hDEAD_BEEF, 1'b0, lat, bb, hb);
        checks++; if (hb !== 0) begin failures++; $display("FAIL zero_hold got=%0d changed cycles exp=0", hb); end
        checks++; if ({hi, lo} !== 64'd0) begin failures++; $display("FAIL zero_result got=%h_%h exp=0", hi, lo); end
        tick();
    endtask

    task automatic test_random();
        int lat, bb, hb, idle;
        logic [31:0] x, y;
        logic        s;
        logic [63:0] exp_v;
        for (int i = 0; i < 24; i++) begin
            x = $urandom; y = $urandom; s = 1'($urandom);
            case (i % 8)
                0: x = 32'h8000_0000;
                1: y = 32'hFFFF_FFFF;
                2: x = 32'h0;
                default: ;
            endcase
            exp_v = ref_mul(x, y, s);
            run_op(x, y, s, lat, bb, hb);
            checks++; if (lat !== 32 || bb !== 0) begin failures++; $display("FAIL rand%0d_timing got lat=%0d busy_low=%0d exp 32 0", i, lat, bb); end
            checks++; if ({hi, lo} !== exp_v) begin failures++; $display("FAIL rand%0d_result a=%h b=%h s=%0b got=%h_%h exp=%h", i, x, y, s, hi, lo, exp_v); end
            idle = int'($urandom_range(2, 0));
            repeat (idle) tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_ones();
        test_signed();
        test_start_ignored();
        test_reset_mid();
        test_zero_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
